// File: rtl/control_unit.sv
// Hardwired Moore controller that sequences the data_path through fetch,
// decode and execute for data-processing, LDR/STR(B) and B/BL instructions.
module control_unit #(
  parameter logic [4:0]  OP_ADD      = 5'b00100,
  parameter logic [4:0]  OP_SUB      = 5'b00010,
  parameter logic [4:0]  OP_PASSB    = 5'b01101,
  parameter logic [4:0]  OP_INC4     = 5'b10000,
  parameter int unsigned MOC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_OUT,
  input  logic        MOC,
  input  logic        Cond,
  output logic        SE,
  output logic        FR_ld,
  output logic        RF_ld,
  output logic        IR_ld,
  output logic        MAR_ld,
  output logic        MDR_ld,
  output logic        R_W,
  output logic        MOV,
  output logic        C_in,
  output logic        MD,
  output logic        ME,
  output logic [1:0]  size,
  output logic [1:0]  MA,
  output logic [1:0]  MB,
  output logic [2:0]  MC,
  output logic [4:0]  OP,
  output logic [3:0]  state,
  output logic        fault,
  output logic        undef
);

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_F0    = 4'd1,
    S_F1    = 4'd2,
    S_F2    = 4'd3,
    S_DEC   = 4'd4,
    S_DP    = 4'd5,
    S_LS0   = 4'd6,
    S_LD1   = 4'd7,
    S_LD2   = 4'd8,
    S_ST0   = 4'd9,
    S_ST1   = 4'd10,
    S_BR0   = 4'd11,
    S_BR1   = 4'd12,
    S_FAULT = 4'd15
  } state_t;

  localparam int unsigned CW = $clog2(MOC_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MOC_TIMEOUT - 1);
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b00;

  state_t        cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic          undef_q;
  logic          undef_set;

  logic [2:0] ir_class;
  logic [3:0] ir_opc;
  logic       dp_ok, ls_ok, br_ok;
  logic       wait_state, timeout;
  logic [1:0] ls_size;
  logic       unused_ir;

  assign ir_class   = IR_OUT[27:25];
  assign ir_opc     = IR_OUT[24:21];
  assign dp_ok      = (ir_class == 3'b000 || ir_class == 3'b001) &&
                      !(ir_opc inside {4'd5, 4'd6, 4'd7});
  assign ls_ok      = (ir_class == 3'b010) && IR_OUT[24] && !IR_OUT[21];
  assign br_ok      = (ir_class == 3'b101);
  assign ls_size    = IR_OUT[22] ? SZ_BYTE : SZ_WORD;
  assign wait_state = (cur == S_F2) || (cur == S_LD1) || (cur == S_ST1);
  assign timeout    = wait_state && !MOC && (wait_cnt == WAIT_LAST);
  assign undef_set  = (cur == S_DEC) && Cond && !(dp_ok || ls_ok || br_ok);
  assign unused_ir  = ^{IR_OUT[31:28], IR_OUT[19:0]};

  assign state = cur;
  assign undef = undef_q;

  // State register, MOC wait counter and the registered undef pulse.
  // undef is registered so Cond never reaches an output combinationally;
  // it is visible during the F0 cycle that follows the skipping DEC.
  always_ff @(posedge clk) begin
    if (clr) begin
      cur      <= S_RST;
      wait_cnt <= '0;
      undef_q  <= 1'b0;
    end else begin
      cur     <= nxt;
      undef_q <= undef_set;
      if (wait_state && nxt == cur)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Next-state selection.
  always_comb begin
    nxt = cur;
    case (cur)
      S_RST: nxt = S_F0;
      S_F0:  nxt = S_F1;
      S_F1:  nxt = S_F2;
      S_F2: begin
        if (MOC)          nxt = S_DEC;
        else if (timeout) nxt = S_FAULT;
      end
      S_DEC: begin
        if (!Cond)      nxt = S_F0;
        else if (dp_ok) nxt = S_DP;
        else if (ls_ok) nxt = S_LS0;
        else if (br_ok) nxt = IR_OUT[24] ? S_BR0 : S_BR1;
        else            nxt = S_F0;
      end
      S_DP:  nxt = S_F0;
      S_LS0: nxt = IR_OUT[20] ? S_LD1 : S_ST0;
      S_LD1: begin
        if (MOC)          nxt = S_LD2;
        else if (timeout) nxt = S_FAULT;
      end
      S_LD2: nxt = S_F0;
      S_ST0: nxt = S_ST1;
      S_ST1: begin
        if (MOC)          nxt = S_F0;
        else if (timeout) nxt = S_FAULT;
      end
      S_BR0:   nxt = S_BR1;
      S_BR1:   nxt = S_F0;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_RST;
    endcase
  end

  // Moore output decode from the registered state and IR.
  always_comb begin
    SE     = 1'b0;
    FR_ld  = 1'b0;
    RF_ld  = 1'b0;
    IR_ld  = 1'b0;
    MAR_ld = 1'b0;
    MDR_ld = 1'b0;
    R_W    = 1'b0;
    MOV    = 1'b0;
    C_in   = 1'b0;
    MD     = 1'b0;
    ME     = 1'b0;
    size   = '0;
    MA     = '0;
    MB     = '0;
    MC     = '0;
    OP     = '0;
    fault  = 1'b0;
    case (cur)
      S_F0: begin
        MA = 2'd2; MB = 2'd3; MD = 1'b1; OP = OP_ADD; MAR_ld = 1'b1;
      end
      S_F1: begin
        MA = 2'd2; MD = 1'b1; OP = OP_INC4; MC = 3'd1; RF_ld = 1'b1;
        MOV = 1'b1; R_W = 1'b1; size = SZ_WORD;
      end
      S_F2: begin
        MOV = 1'b1; R_W = 1'b1; size = SZ_WORD; IR_ld = 1'b1;
      end
      S_DP: begin
        MB    = 2'd1;
        FR_ld = IR_OUT[20];
        RF_ld = (ir_opc[3:2] != 2'b10);
      end
      S_LS0: begin
        MB = 2'd1; MD = 1'b1; MAR_ld = 1'b1;
        OP = IR_OUT[23] ? OP_ADD : OP_SUB;
      end
      S_LD1: begin
        MOV = 1'b1; R_W = 1'b1; MDR_ld = 1'b1; size = ls_size;
      end
      S_LD2: begin
        MB = 2'd2; MD = 1'b1; OP = OP_PASSB; RF_ld = 1'b1;
      end
      S_ST0: begin
        MA = 2'd1; MB = 2'd3; MD = 1'b1; OP = OP_ADD; ME = 1'b1; MDR_ld = 1'b1;
      end
      S_ST1: begin
        MOV = 1'b1; size = ls_size;
      end
      S_BR0: begin
        MA = 2'd2; MB = 2'd3; MD = 1'b1; OP = OP_ADD; MC = 3'd4; RF_ld = 1'b1;
      end
      S_BR1: begin
        MA = 2'd2; MB = 2'd1; MD = 1'b1; OP = OP_ADD; MC = 3'd1; RF_ld = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instructions plus random
// instruction streams checked cycle-by-cycle against an instruction-level model.
module tb_control_unit;

  localparam logic [4:0] ADD   = 5'b00100;
  localparam logic [4:0] SUB   = 5'b00010;
  localparam logic [4:0] PASSB = 5'b01101;
  localparam logic [4:0] INC4  = 5'b10000;
  localparam int         TMO   = 16;

  logic        clk = 1'b0;
  logic        clr, MOC, Cond;
  logic [31:0] IR_OUT;
  logic SE, FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV, C_in, MD, ME;
  logic [1:0] size, MA, MB;
  logic [2:0] MC;
  logic [4:0] OP;
  logic [3:0] state;
  logic       fault, undef;

  typedef struct packed {
    logic SE, FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV, C_in, MD, ME;
    logic [1:0] size, MA, MB;
    logic [2:0] MC;
    logic [4:0] OP;
    logic fault, undef;
  } ctl_t;

  typedef struct packed {
    logic [3:0]  st;
    ctl_t        c;
    logic        moc;
    logic [31:0] ir;
    logic        cond;
  } item_t;

  ctl_t  act;
  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  logic  pend_undef = 1'b0;
  logic [31:0] cur_ir;
  logic        cur_cond;

  assign act = {SE, FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV, C_in, MD, ME,
                size, MA, MB, MC, OP, fault, undef};

  control_unit #(.MOC_TIMEOUT(TMO)) dut (
    .clk(clk), .clr(clr), .IR_OUT(IR_OUT), .MOC(MOC), .Cond(Cond),
    .SE(SE), .FR_ld(FR_ld), .RF_ld(RF_ld), .IR_ld(IR_ld), .MAR_ld(MAR_ld),
    .MDR_ld(MDR_ld), .R_W(R_W), .MOV(MOV), .C_in(C_in), .MD(MD), .ME(ME),
    .size(size), .MA(MA), .MB(MB), .MC(MC), .OP(OP), .state(state),
    .fault(fault), .undef(undef)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic push(input logic [3:0] st, input ctl_t c, input logic moc);
    item_t it;
    it.st = st; it.c = c; it.moc = moc; it.ir = cur_ir; it.cond = cur_cond;
    q.push_back(it);
  endtask

  // A memory wait lasting d cycles before MOC; d >= TMO never sees MOC and faults.
  task automatic model_wait(input logic [3:0] st, input ctl_t c, input int d, output bit to);
    ctl_t f;
    to = (d >= TMO);
    for (int i = 0; i < (to ? TMO : d + 1); i++) push(st, c, (!to && i == d));
    if (to) begin
      f = '0; f.fault = 1'b1;
      for (int i = 0; i < 4; i++) push(4'd15, f, 1'b1);
    end
  endtask

  // Expected per-cycle trace of one instruction, starting at F0.
  task automatic model_instr(input logic [31:0] ir, input logic cond, input int d1, input int d2);
    ctl_t c;
    bit to;
    logic [2:0] cls;
    logic [3:0] opc;
    cur_ir = ir; cur_cond = cond;
    cls = ir[27:25]; opc = ir[24:21];
    c = '0; c.MA = 2; c.MB = 3; c.MD = 1; c.OP = ADD; c.MAR_ld = 1; c.undef = pend_undef;
    pend_undef = 1'b0;
    push(4'd1, c, 1'b0);
    c = '0; c.MA = 2; c.MD = 1; c.OP = INC4; c.MC = 1; c.RF_ld = 1; c.MOV = 1; c.R_W = 1; c.size = 2;
    push(4'd2, c, 1'b0);
    c = '0; c.MOV = 1; c.R_W = 1; c.size = 2; c.IR_ld = 1;
    model_wait(4'd3, c, d1, to);
    if (to) return;
    c = '0; push(4'd4, c, 1'b0);
    if (!cond) return;
    if ((cls == 3'd0 || cls == 3'd1) && !(opc inside {4'd5, 4'd6, 4'd7})) begin
      c = '0; c.MB = 1; c.FR_ld = ir[20]; c.RF_ld = !(opc inside {[4'd8:4'd11]});
      push(4'd5, c, 1'b0);
    end else if (cls == 3'd2 && ir[24] && !ir[21]) begin
      c = '0; c.MB = 1; c.MD = 1; c.OP = ir[23] ? ADD : SUB; c.MAR_ld = 1;
      push(4'd6, c, 1'b0);
      if (ir[20]) begin
        c = '0; c.MOV = 1; c.R_W = 1; c.MDR_ld = 1; c.size = ir[22] ? 2'd0 : 2'd2;
        model_wait(4'd7, c, d2, to);
        if (to) return;
        c = '0; c.MB = 2; c.MD = 1; c.OP = PASSB; c.RF_ld = 1;
        push(4'd8, c, 1'b0);
      end else begin
        c = '0; c.MA = 1; c.MB = 3; c.MD = 1; c.OP = ADD; c.ME = 1; c.MDR_ld = 1;
        push(4'd9, c, 1'b0);
        c = '0; c.MOV = 1; c.size = ir[22] ? 2'd0 : 2'd2;
        model_wait(4'd10, c, d2, to);
      end
    end else if (cls == 3'd5) begin
      if (ir[24]) begin
        c = '0; c.MA = 2; c.MB = 3; c.MD = 1; c.OP = ADD; c.MC = 4; c.RF_ld = 1;
        push(4'd11, c, 1'b0);
      end
      c = '0; c.MA = 2; c.MB = 1; c.MD = 1; c.OP = ADD; c.MC = 1; c.RF_ld = 1;
      push(4'd12, c, 1'b0);
    end else begin
      pend_undef = 1'b1;
    end
  endtask

  function automatic int rand_delay();
    return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
  endfunction

  task automatic test_reset();
    ctl_t f0;
    clr = 1'b1; MOC = 1'b0; Cond = 1'b0; IR_OUT = '0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || act !== ctl_t'('0)) begin
      errors++;
      $display("FAIL reset_rst: state=%0d ctl=%h, expected state=0 ctl=0", state, act);
    end
    clr = 1'b0;
    @(negedge clk);
    f0 = '0; f0.MAR_ld = 1; f0.MA = 2; f0.MB = 3; f0.MD = 1; f0.OP = ADD;
    checks++;
    if (state !== 4'd1 || act !== f0) begin
      errors++;
      $display("FAIL reset_f0: state=%0d ctl=%h, expected state=1 ctl=%h", state, act, f0);
    end
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || act !== ctl_t'('0)) begin
      errors++;
      $display("FAIL reset_from_f0: state=%0d ctl=%h, expected state=0 ctl=0", state, act);
    end
    clr = 1'b0;
    pend_undef = 1'b0;
  endtask

  task automatic test_data_proc();
    item_t it;
    model_instr(32'hE0821003, 1'b1, 1, 0);
    model_instr(32'hE1510002, 1'b1, 0, 0);
    model_instr(32'hE0A21003, 1'b1, 2, 0);
    model_instr(32'hE0821003, 1'b1, 0, 0);
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clk);
      checks++;
      if (state !== it.st || act !== it.c) begin
        errors++;
        $display("FAIL data_proc ir=%h: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 it.ir, state, act, it.st, it.c);
      end
      MOC = it.moc; IR_OUT = it.ir; Cond = it.cond;
    end
  endtask

  task automatic test_load_store();
    item_t it;
    model_instr(32'hE5D10004, 1'b1, 0, 0);
    model_instr(32'hE5010008, 1'b1, 1, 3);
    model_instr(32'hE5910000, 1'b1, 0, 15);
    model_instr(32'hE5C10000, 1'b1, 15, 2);
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clk);
      checks++;
      if (state !== it.st || act !== it.c) begin
        errors++;
        $display("FAIL load_store ir=%h: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 it.ir, state, act, it.st, it.c);
      end
      MOC = it.moc; IR_OUT = it.ir; Cond = it.cond;
    end
  endtask

  task automatic test_branch();
    item_t it;
    model_instr(32'hEB000002, 1'b0, 0, 0);
    model_instr(32'hEB000002, 1'b1, 0, 0);
    model_instr(32'hEAFFFFFE, 1'b1, 1, 0);
    model_instr(32'hE1510002, 1'b0, 0, 0);
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clk);
      checks++;
      if (state !== it.st || act !== it.c) begin
        errors++;
        $display("FAIL branch ir=%h: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 it.ir, state, act, it.st, it.c);
      end
      MOC = it.moc; IR_OUT = it.ir; Cond = it.cond;
    end
  endtask

  task automatic test_random();
    item_t it;
    logic [31:0] ir;
    int kind;
    for (int n = 0; n < 200; n++) begin
      ir = $urandom();
      kind = $urandom_range(0, 9);
      if (kind <= 3) ir[27:26] = 2'b00;
      else if (kind <= 5) begin
        ir[27:25] = 3'b010;
        if ($urandom_range(0, 3) != 0) begin ir[24] = 1'b1; ir[21] = 1'b0; end
      end else if (kind <= 7) ir[27:25] = 3'b101;
      model_instr(ir, ($urandom_range(0, 4) != 0), rand_delay(), rand_delay());
    end
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clk);
      checks++;
      if (state !== it.st || act !== it.c) begin
        errors++;
        $display("FAIL random ir=%h: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 it.ir, state, act, it.st, it.c);
      end
      MOC = it.moc; IR_OUT = it.ir; Cond = it.cond;
    end
  endtask

  task automatic test_reset_midflight();
    item_t it;
    model_instr(32'hE5D10004, 1'b1, 0, 5);
    for (int n = 0; n < 6; n++) begin
      it = q.pop_front();
      @(negedge clk);
      checks++;
      if (state !== it.st || act !== it.c) begin
        errors++;
        $display("FAIL midflight ir=%h: state=%0d ctl=%h, expected state=%0d ctl=%h",
                 it.ir, state, act, it.st, it.c);
      end
      MOC = it.moc; IR_OUT = it.ir; Cond = it.cond;
    end
    q.delete();
    clr = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || act !== ctl_t'('0)) begin
        errors++;
        $display("FAIL midflight_rst: state=%0d ctl=%h, expected state=0 ctl=0", state, act);
      end
    end
    clr = 1'b0;
    pend_undef = 1'b0;
  endtask

  task automatic test_fault();
    item_t it;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) model_instr(32'hE0821003, 1'b1, TMO, 0);
      else        model_instr(32'hE5D10004, 1'b1, 0, TMO);
      while (q.size() > 0) begin
        it = q.pop_front();
        @(negedge clk);
        checks++;
        if (state !== it.st || act !== it.c) begin
          errors++;
          $display("FAIL fault%0d ir=%h: state=%0d ctl=%h, expected state=%0d ctl=%h",
                   k, it.ir, state, act, it.st, it.c);
        end
        MOC = it.moc; IR_OUT = it.ir; Cond = it.cond;
      end
      clr = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL fault%0d_clear: state=%0d fault=%b, expected state=0 fault=0", k, state, fault);
      end
      clr = 1'b0; MOC = 1'b0;
      pend_undef = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_data_proc();
    test_load_store();
    test_branch();
    test_reset_midflight();
    test_random();
    test_fault();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
